// File: rtl/store_buffer.sv
// store_buffer: posted-write queue between the MEM stage and the data RAM.
// Stores are queued in a circular FIFO and retire on cycles that no load needs
// the RAM port. Loads forward from the youngest exact match. A load that only
// partially overlaps a queued store stalls until the conflicting stores drain.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 9,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  input  logic [1:0]               st_size,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  input  logic [1:0]               ld_size,
  input  logic                     ld_se,
  output logic                     ld_hit,
  output logic [DW-1:0]            ld_data,
  output logic                     ld_stall,
  input  logic                     drain_all,
  output logic                     ram_e,
  output logic                     ram_rw,
  output logic [AW-1:0]            ram_a,
  output logic [DW-1:0]            ram_di,
  output logic [1:0]               ram_size,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [1:0]    size_q [DEPTH];
  logic [1:0]    size_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          push;
  logic          pop;
  logic          match_any;
  logic          match_exact;
  logic [DW-1:0] match_data;
  logic [PW-1:0] idx;
  logic          ext_bit;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign st_ready = !full && !drain_all;
  assign push     = st_valid && st_ready;

  // Scan valid entries oldest to youngest so the last word match wins.
  always_comb begin
    match_any   = 1'b0;
    match_exact = 1'b0;
    match_data  = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx][AW-1:2] == ld_addr[AW-1:2])) begin
        match_any   = 1'b1;
        match_exact = (addr_q[idx] == ld_addr) && (size_q[idx] == ld_size);
        match_data  = data_q[idx];
      end
    end
  end

  // Forwarded data is truncated to the load size, then sign- or zero-extended.
  always_comb begin
    ld_hit   = ld_valid && match_any && match_exact;
    ld_stall = ld_valid && match_any && !match_exact;
    ld_data  = '0;
    ext_bit  = 1'b0;
    if (ld_hit) begin
      case (ld_size)
        2'b00: begin
          ext_bit = ld_se && match_data[7];
          ld_data = {{(DW-8){ext_bit}}, match_data[7:0]};
        end
        2'b01: begin
          ext_bit = ld_se && match_data[15];
          ld_data = {{(DW-16){ext_bit}}, match_data[15:0]};
        end
        default: ld_data = match_data;
      endcase
    end
  end

  // RAM port arbitration: a non-stalled load reads, otherwise the head drains.
  always_comb begin
    ram_e    = 1'b0;
    ram_rw   = 1'b0;
    ram_a    = '0;
    ram_di   = '0;
    ram_size = '0;
    pop      = 1'b0;
    if (ld_valid && !ld_stall) begin
      ram_e    = 1'b1;
      ram_a    = ld_addr;
      ram_size = ld_size;
    end else if (!empty) begin
      ram_e    = 1'b1;
      ram_rw   = 1'b1;
      ram_a    = addr_q[head_q];
      ram_di   = data_q[head_q];
      ram_size = size_q[head_q];
      pop      = 1'b1;
    end
  end

  // Next-state for the queue: write at tail on push, advance head on pop.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      addr_d[tail_q] = st_addr;
      data_d[tail_q] = st_data;
      size_d[tail_q] = st_size;
      tail_d         = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state registers; reset discards everything queued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        size_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed test of store_buffer with hand-computed expectations.
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [8:0]  st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_ready;
  logic        ld_valid;
  logic [8:0]  ld_addr;
  logic [1:0]  ld_size;
  logic        ld_se;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        drain_all;
  logic        ram_e;
  logic        ram_rw;
  logic [8:0]  ram_a;
  logic [31:0] ram_di;
  logic [1:0]  ram_size;
  logic        empty;
  logic [2:0]  count;

  int n_vec;
  int n_err;

  store_buffer #(.DEPTH(4), .AW(9), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size), .ld_se(ld_se),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
    .drain_all(drain_all),
    .ram_e(ram_e), .ram_rw(ram_rw), .ram_a(ram_a), .ram_di(ram_di), .ram_size(ram_size),
    .empty(empty), .count(count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and return all request inputs to idle, 1 unit after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    st_valid  = 1'b0;
    ld_valid  = 1'b0;
    ld_se     = 1'b0;
    drain_all = 1'b0;
  endtask

  task automatic do_store(input logic [8:0] a, input logic [31:0] d, input logic [1:0] sz);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = sz;
  endtask

  task automatic do_load(input logic [8:0] a, input logic [1:0] sz, input logic se);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_size  = sz;
    ld_se    = se;
  endtask

  task automatic expect_write(input string tag, input logic [8:0] a, input logic [31:0] d,
                              input logic [1:0] sz);
    check_output({tag, ".ram_e"},    32'(ram_e),    32'd1);
    check_output({tag, ".ram_rw"},   32'(ram_rw),   32'd1);
    check_output({tag, ".ram_a"},    32'(ram_a),    32'(a));
    check_output({tag, ".ram_di"},   ram_di,        d);
    check_output({tag, ".ram_size"}, 32'(ram_size), 32'(sz));
  endtask

  // Directed sequence: reset, drain, full, forwarding, overlap, fence, mid-stream reset.
  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b0;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    st_size   = '0;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ld_size   = '0;
    ld_se     = 1'b0;
    drain_all = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_output("rst.count",    32'(count),    32'd0);
    check_output("rst.empty",    32'(empty),    32'd1);
    check_output("rst.st_ready", 32'(st_ready), 32'd1);
    check_output("rst.ram_e",    32'(ram_e),    32'd0);
    check_output("rst.ram_rw",   32'(ram_rw),   32'd0);
    check_output("rst.ld_hit",   32'(ld_hit),   32'd0);
    check_output("rst.ld_stall", 32'(ld_stall), 32'd0);
    check_output("rst.ld_data",  ld_data,       32'd0);
    check_output("rst.ram_a",    32'(ram_a),    32'd0);
    check_output("rst.ram_di",   ram_di,        32'd0);
    check_output("rst.ram_size", 32'(ram_size), 32'd0);
    reset = 1'b1;

    // Single store drains one cycle after acceptance.
    next_cycle();
    do_store(9'h010, 32'hDEADBEEF, 2'b10);
    #1;
    check_output("single.st_ready", 32'(st_ready), 32'd1);
    check_output("single.no_write", 32'(ram_e),    32'd0);
    next_cycle();
    #1;
    check_output("single.count1", 32'(count), 32'd1);
    expect_write("single.wr", 9'h010, 32'hDEADBEEF, 2'b10);
    next_cycle();
    #1;
    check_output("single.count0", 32'(count), 32'd0);
    check_output("single.empty",  32'(empty), 32'd1);
    check_output("single.idle",   32'(ram_e), 32'd0);

    // Fill the buffer while loads hold the RAM port.
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      do_load(9'h100, 2'b10, 1'b0);
      do_store(9'(4 * k), 32'(32'hA0 + k), 2'b10);
      #1;
      check_output("full.fill_ready", 32'(st_ready), 32'd1);
      check_output("full.fill_read",  32'(ram_rw),   32'd0);
      check_output("full.fill_addr",  32'(ram_a),    32'h100);
    end
    next_cycle();
    do_load(9'h100, 2'b10, 1'b0);
    do_store(9'h014, 32'hA4, 2'b10);
    #1;
    check_output("full.count4",    32'(count),    32'd4);
    check_output("full.refuse",    32'(st_ready), 32'd0);
    next_cycle();
    do_store(9'h014, 32'hA4, 2'b10);
    #1;
    check_output("full.refuse_on_pop", 32'(st_ready), 32'd0);
    expect_write("full.wr0", 9'h000, 32'hA0, 2'b10);
    next_cycle();
    do_store(9'h014, 32'hA4, 2'b10);
    #1;
    check_output("full.count3", 32'(count),    32'd3);
    check_output("full.accept", 32'(st_ready), 32'd1);
    expect_write("full.wr1", 9'h004, 32'hA1, 2'b10);
    next_cycle();
    #1;
    expect_write("full.wr2", 9'h008, 32'hA2, 2'b10);
    next_cycle();
    #1;
    expect_write("full.wr3", 9'h00C, 32'hA3, 2'b10);
    next_cycle();
    #1;
    expect_write("full.wr4", 9'h014, 32'hA4, 2'b10);
    next_cycle();
    #1;
    check_output("full.empty", 32'(empty), 32'd1);

    // Forwarding picks the youngest exact match.
    next_cycle();
    do_load(9'h100, 2'b10, 1'b0);
    do_store(9'h021, 32'h80, 2'b00);
    next_cycle();
    do_load(9'h100, 2'b10, 1'b0);
    do_store(9'h021, 32'h7F, 2'b00);
    next_cycle();
    do_load(9'h021, 2'b00, 1'b1);
    #1;
    check_output("fwd.hit1",   32'(ld_hit),   32'd1);
    check_output("fwd.data1",  ld_data,       32'h0000007F);
    check_output("fwd.stall1", 32'(ld_stall), 32'd0);
    check_output("fwd.read1",  32'(ram_rw),   32'd0);
    check_output("fwd.addr1",  32'(ram_a),    32'h021);
    next_cycle();
    do_load(9'h100, 2'b10, 1'b0);
    do_store(9'h021, 32'h80, 2'b00);
    next_cycle();
    do_load(9'h021, 2'b00, 1'b1);
    #1;
    check_output("fwd.count3", 32'(count), 32'd3);
    check_output("fwd.hit2",   32'(ld_hit), 32'd1);
    check_output("fwd.data_se", ld_data,    32'hFFFFFF80);
    ld_se = 1'b0;
    #1;
    check_output("fwd.data_ze", ld_data, 32'h00000080);
    do_load(9'h020, 2'b01, 1'b0);
    #1;
    check_output("fwd.part_stall", 32'(ld_stall), 32'd1);
    check_output("fwd.part_hit",   32'(ld_hit),   32'd0);
    expect_write("fwd.wr0", 9'h021, 32'h80, 2'b00);
    next_cycle();
    #1;
    expect_write("fwd.wr1", 9'h021, 32'h7F, 2'b00);
    next_cycle();
    #1;
    expect_write("fwd.wr2", 9'h021, 32'h80, 2'b00);
    next_cycle();
    #1;
    check_output("fwd.empty", 32'(empty), 32'd1);

    // Halfword forwarding truncates the upper store bits.
    next_cycle();
    do_store(9'h050, 32'hABCD8001, 2'b01);
    next_cycle();
    do_load(9'h050, 2'b01, 1'b0);
    #1;
    check_output("half.hit",     32'(ld_hit), 32'd1);
    check_output("half.data_ze", ld_data,     32'h00008001);
    ld_se = 1'b1;
    #1;
    check_output("half.data_se", ld_data, 32'hFFFF8001);
    next_cycle();
    #1;
    expect_write("half.wr", 9'h050, 32'hABCD8001, 2'b01);

    // Partial overlap stalls for one drain cycle, then the load reads RAM.
    next_cycle();
    do_store(9'h040, 32'h11223344, 2'b10);
    next_cycle();
    do_load(9'h042, 2'b01, 1'b0);
    #1;
    check_output("ovl.stall", 32'(ld_stall), 32'd1);
    check_output("ovl.hit",   32'(ld_hit),   32'd0);
    expect_write("ovl.wr", 9'h040, 32'h11223344, 2'b10);
    next_cycle();
    do_load(9'h042, 2'b01, 1'b0);
    #1;
    check_output("ovl.unstall", 32'(ld_stall), 32'd0);
    check_output("ovl.ram_e",   32'(ram_e),    32'd1);
    check_output("ovl.read",    32'(ram_rw),   32'd0);
    check_output("ovl.addr",    32'(ram_a),    32'h042);
    check_output("ovl.size",    32'(ram_size), 32'd1);

    // Six stores with interleaved pops wrap both pointers, then fence.
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      do_load(9'h100, 2'b10, 1'b0);
      do_store(9'(32'h80 + 4 * k), 32'(32'hC0 + k), 2'b10);
    end
    for (int k = 3; k < 6; k++) begin
      next_cycle();
      do_store(9'(32'h80 + 4 * k), 32'(32'hC0 + k), 2'b10);
      #1;
      expect_write("wrap.wr", 9'(32'h80 + 4 * (k - 3)), 32'(32'hC0 + k - 3), 2'b10);
    end
    next_cycle();
    drain_all = 1'b1;
    do_store(9'h0A0, 32'hDD, 2'b10);
    #1;
    check_output("fence.refuse", 32'(st_ready), 32'd0);
    expect_write("fence.wr3", 9'h08C, 32'hC3, 2'b10);
    next_cycle();
    drain_all = 1'b1;
    do_load(9'h100, 2'b10, 1'b0);
    #1;
    check_output("fence.load_wins", 32'(ram_rw), 32'd0);
    check_output("fence.count2",    32'(count),  32'd2);
    next_cycle();
    drain_all = 1'b1;
    #1;
    expect_write("fence.wr4", 9'h090, 32'hC4, 2'b10);
    next_cycle();
    drain_all = 1'b1;
    #1;
    expect_write("fence.wr5", 9'h094, 32'hC5, 2'b10);
    next_cycle();
    drain_all = 1'b1;
    #1;
    check_output("fence.empty",  32'(empty),    32'd1);
    check_output("fence.idle",   32'(ram_e),    32'd0);
    check_output("fence.refuse2", 32'(st_ready), 32'd0);
    next_cycle();
    #1;
    check_output("fence.release", 32'(st_ready), 32'd1);
    check_output("fence.count0",  32'(count),    32'd0);

    // Reset with three stores queued discards them without any RAM write.
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      do_load(9'h100, 2'b10, 1'b0);
      do_store(9'(32'hC0 + 4 * k), 32'(32'hE0 + k), 2'b10);
    end
    next_cycle();
    do_load(9'h100, 2'b10, 1'b0);
    #1;
    check_output("mid.count3", 32'(count), 32'd3);
    ld_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check_output("mid.count0",   32'(count),    32'd0);
    check_output("mid.empty",    32'(empty),    32'd1);
    check_output("mid.st_ready", 32'(st_ready), 32'd1);
    check_output("mid.ram_e",    32'(ram_e),    32'd0);
    next_cycle();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      #1;
      check_output("mid.no_write", 32'(ram_e), 32'd0);
      check_output("mid.empty2",   32'(empty), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
